// File: rtl/uart_pkg.sv
// UART shared definitions: frame layout, line level, baud divider.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_IDX = DATA_BITS + 1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_FRAME,
        RX_WAIT_IDLE
    } rx_state_t;

    // Clocks per bit; integer divide, remainder ignored.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Resets to RST_VAL (all ones by default, i.e. idle-high lines).
module sync_2ff #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives a clean level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop sync, 3-sample majority per bit,
// one-entry valid/ready output register with error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW = $clog2(DIV);
    localparam int BW = $clog2(STOP_IDX + 1);

    localparam logic [CW-1:0] C_S0 = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1 = CW'(HALF);
    localparam logic [CW-1:0] C_DEC = CW'(HALF + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] B_STOP = BW'(STOP_IDX);

    generate
        if (DIV < 8) begin : g_div_check
            $error("uart_rx: CLK_FREQ_HZ/BAUD must be >= 8");
        end
    endgenerate

    rx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] byte_q;
    logic s0_q, s1_q;
    logic rx_s;
    logic maj;
    logic done_d, done_q;
    logic err_d;

    sync_2ff #(
        .WIDTH(1),
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d(rx_line),
        .q(rx_s)
    );

    // Third sample is the live rx_s in the decision cycle.
    assign maj = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    assign rx_busy = (state_q != RX_IDLE);

    // Frame state, bit timing and data shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Capture the two early mid-bit samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            if (cnt_q == C_S0) s0_q <= rx_s;
            if (cnt_q == C_S1) s1_q <= rx_s;
        end
    end

    // Next-state logic: start detect, bit decisions, stop check.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_s != IDLE_LEVEL) begin
                    state_d = RX_FRAME;
                    cnt_d   = CW'(1);
                end
            end
            RX_FRAME: begin
                if (cnt_q == C_LAST) begin
                    cnt_d = '0;
                    bit_d = bit_q + BW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_q == C_DEC) begin
                    if (bit_q == '0) begin
                        if (maj) begin
                            state_d = RX_IDLE;
                            cnt_d   = '0;
                            bit_d   = '0;
                        end
                    end else if (bit_q == B_STOP) begin
                        cnt_d = '0;
                        bit_d = '0;
                        if (maj) begin
                            state_d = RX_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RX_WAIT_IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                    end
                end
            end
            RX_WAIT_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_s == IDLE_LEVEL) state_d = RX_IDLE;
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Hold the completed byte so a new frame can start immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            byte_q <= '0;
        end else begin
            done_q <= done_d;
            if (done_d) byte_q <= shreg_q;
        end
    end

    // One-entry output register with overrun and framing pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= err_d;
            rx_overrun   <= 1'b0;
            if (done_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= byte_q;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 25 clocks per bit.
// Table of single frames plus hand-written corner sequences.
module tb_uart_rx;

    localparam int DIV = 25;
    localparam int HALF = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_line = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    uart_rx #(
        .CLK_FREQ_HZ(50000000),
        .BAUD(2000000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_line(rx_line),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun),
        .rx_busy(rx_busy)
    );

    always #10 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_bytes = 0;
    int n_err = 0;
    int n_ovr = 0;
    int first_valid_k = -1;
    logic [7:0] rxq[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_bytes;
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    // Consumer-side monitor: handshakes and error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                rxq.push_back(rx_data);
                n_bytes++;
            end
            if (rx_frame_err) n_err++;
            if (rx_overrun) n_ovr++;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [31:0] last_byte();
        if (rxq.size() == 0) return 32'hFFFF;
        return {24'h0, rxq[rxq.size()-1]};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; k counts edges since the start bit was driven.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int ready_edge);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        first_valid_k = -1;
        for (int k = 0; k < 10 * DIV; k++) begin
            rx_line = bits[k/DIV];
            if (ready_edge >= 0) begin
                if (k == ready_edge) rx_ready = 1'b1;
                else if (k == ready_edge + 1) rx_ready = 1'b0;
            end
            if (rx_valid && first_valid_k < 0) first_valid_k = k;
            tick(1);
        end
    endtask

    initial begin
        int b0, e0, o0, bad;
        logic [9:0] abits;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 1};
        vecs[4] = '{8'h81, 1'b1, 1, 0};
        vecs[5] = '{8'h55, 1'b1, 1, 0};
        vecs[6] = '{8'h01, 1'b1, 1, 0};
        vecs[7] = '{8'h80, 1'b1, 1, 0};

        tick(3);
        check("rst_valid", {31'h0, rx_valid}, 0);
        check("rst_data", {24'h0, rx_data}, 0);
        check("rst_busy", {31'h0, rx_busy}, 0);
        check("rst_ferr", {31'h0, rx_frame_err}, 0);
        check("rst_ovr", {31'h0, rx_overrun}, 0);
        rst = 1'b0;
        rx_ready = 1'b1;
        tick(2 * DIV);

        // Latency of the first byte from the rx_line fall.
        b0 = n_bytes; e0 = n_err;
        send_frame(8'hA5, 1'b1, -1);
        check("lat_edge", first_valid_k, 242);
        tick(2 * DIV);
        check("lat_cnt", n_bytes - b0, 1);
        check("lat_data", last_byte(), 32'hA5);
        check("lat_ferr", n_err - e0, 0);

        foreach (vecs[i]) begin
            b0 = n_bytes; e0 = n_err; o0 = n_ovr;
            send_frame(vecs[i].data, vecs[i].stop, -1);
            rx_line = 1'b1;
            tick(2 * DIV);
            check($sformatf("vec%0d_bytes", i), n_bytes - b0, vecs[i].exp_bytes);
            check($sformatf("vec%0d_ferr", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_ovr", i), n_ovr - o0, 0);
            if (vecs[i].exp_bytes != 0)
                check($sformatf("vec%0d_data", i), last_byte(), {24'h0, vecs[i].data});
        end

        // Back-to-back frames with a single stop bit.
        b0 = n_bytes; e0 = n_err; o0 = n_ovr;
        for (int i = 0; i < 64; i++) send_frame(8'(i * 4 + 3), 1'b1, -1);
        tick(2 * DIV);
        check("b2b_cnt", n_bytes - b0, 64);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (b0 + i < rxq.size() && rxq[b0 + i] !== 8'(i * 4 + 3)) bad++;
        check("b2b_order", bad, 0);
        check("b2b_ferr", n_err - e0, 0);
        check("b2b_ovr", n_ovr - o0, 0);

        // Short low glitch is a false start.
        b0 = n_bytes; e0 = n_err;
        rx_line = 1'b0;
        tick(3);
        check("gl_busy_hi", {31'h0, rx_busy}, 1);
        tick(2);
        rx_line = 1'b1;
        tick(2 + HALF + 2 - 5);
        check("gl_busy_lo", {31'h0, rx_busy}, 0);
        tick(2 * DIV);
        check("gl_bytes", n_bytes - b0, 0);
        check("gl_ferr", n_err - e0, 0);

        // Bad stop bit followed by a long break.
        b0 = n_bytes; e0 = n_err;
        send_frame(8'h3C, 1'b0, -1);
        tick(40 * DIV);
        check("brk_busy", {31'h0, rx_busy}, 1);
        rx_line = 1'b1;
        tick(3 * DIV);
        check("brk_ferr", n_err - e0, 1);
        check("brk_bytes", n_bytes - b0, 0);
        check("brk_valid", {31'h0, rx_valid}, 0);
        send_frame(8'h81, 1'b1, -1);
        tick(2 * DIV);
        check("brk_next", last_byte(), 32'h81);
        check("brk_next_cnt", n_bytes - b0, 1);

        // Overrun, then consume concurrently with a completing byte.
        rx_ready = 1'b0;
        b0 = n_bytes; o0 = n_ovr;
        send_frame(8'h11, 1'b1, -1);
        tick(2 * DIV);
        send_frame(8'h22, 1'b1, -1);
        tick(2 * DIV);
        check("ovr_data", {24'h0, rx_data}, 32'h11);
        check("ovr_valid", {31'h0, rx_valid}, 1);
        check("ovr_pulse", n_ovr - o0, 1);
        send_frame(8'h33, 1'b1, 241);
        tick(2);
        check("cc_data", {24'h0, rx_data}, 32'h33);
        check("cc_valid", {31'h0, rx_valid}, 1);
        check("cc_ovr", n_ovr - o0, 1);
        check("cc_consumed", last_byte(), 32'h11);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        check("cc_drain", {31'h0, rx_valid}, 0);
        check("cc_bytes", n_bytes - b0, 2);

        // Reset in the middle of a frame with a byte pending.
        send_frame(8'h77, 1'b1, -1);
        tick(2 * DIV);
        check("mr_pend", {31'h0, rx_valid}, 1);
        abits = {1'b1, 8'hC3, 1'b0};
        for (int k = 0; k < 4 * DIV + 10; k++) begin
            rx_line = abits[k/DIV];
            tick(1);
        end
        rst = 1'b1;
        #2;
        check("mr_valid", {31'h0, rx_valid}, 0);
        check("mr_data", {24'h0, rx_data}, 0);
        check("mr_busy", {31'h0, rx_busy}, 0);
        check("mr_ferr", {31'h0, rx_frame_err}, 0);
        check("mr_ovr", {31'h0, rx_overrun}, 0);
        rx_line = 1'b1;
        tick(3);
        rst = 1'b0;
        rx_ready = 1'b1;
        tick(2 * DIV);
        b0 = n_bytes; e0 = n_err;
        send_frame(8'h5A, 1'b1, -1);
        tick(2 * DIV);
        check("mr_next", last_byte(), 32'h5A);
        check("mr_next_cnt", n_bytes - b0, 1);
        check("mr_next_ferr", n_err - e0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
